// File: rtl/spi_slave_fsm.sv
// -----------------------------------------------------------------------------
// spi_slave_fsm
//
// Control FSM for an SPI slave memory. One chip-select frame is sequenced as:
// collect the address and R/W bit, then either load and shift out read data
// or shift in write data and commit it to memory. The FSM runs on the SPI
// serial clock and only observes chip select and the shift-register LSB
// (which carries the R/W bit when the address has just been collected).
//
// Handshake/timing contract: every signal is sampled on the rising edge of
// sclk. chip_sel high at an edge always restarts address collection. Outputs
// are a pure decode of the state register (Moore), at most one is high.
//
// Parameters:
//   ADDR_BITS : address bits received before the R/W bit (default 7)
//   DATA_BITS : data bits shifted in or out (default 8)
//
// Ports:
//   sclk          in  SPI serial clock, rising-edge active
//   reset_n       in  asynchronous active-low reset
//   chip_sel      in  chip select, active low; high ends/aborts the frame
//   shift_reg_out in  shift-register LSB; R/W bit (1 = read, 0 = write)
//   miso_buff     out enable for the MISO tri-state buffer
//   dm_we         out data-memory write enable
//   addr_we       out address-latch write enable
//   sr_we         out shift-register parallel-load enable
//   state_dbg     out (only with SPI_FSM_STATE_OUT_EN) current state encoding
//
// Build option:
//   SPI_FSM_STATE_OUT_EN : when defined, exposes the state register on
//                          state_dbg (GET_ADDR=0 ... DONE=6).
// -----------------------------------------------------------------------------
module spi_slave_fsm #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 8
) (
    input  logic       sclk,
    input  logic       reset_n,
    input  logic       chip_sel,
    input  logic       shift_reg_out,
    output logic       miso_buff,
    output logic       dm_we,
    output logic       addr_we,
`ifdef SPI_FSM_STATE_OUT_EN
    output logic       sr_we,
    output logic [2:0] state_dbg
`else
    output logic       sr_we
`endif
);

    // The counter must hold the address phase length (ADDR_BITS+1 edges
    // including the R/W bit) and the data phase length.
    localparam int MAX_COUNT = ((ADDR_BITS + 1) > DATA_BITS) ? (ADDR_BITS + 1) : DATA_BITS;
    localparam int CNT_W     = $clog2(MAX_COUNT + 1);

    typedef enum logic [2:0] {
        GET_ADDR   = 3'd0,
        GOT_ADDR   = 3'd1,
        READ_LOAD  = 3'd2,
        READ_SHIFT = 3'd3,
        WRITE_GET  = 3'd4,
        WRITE_MEM  = 3'd5,
        DONE       = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= GET_ADDR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Next-state logic. The counter is cleared on every state change, so a
    // phase of N edges ends on the edge where the counter still reads N-1.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        if (chip_sel) begin
            w_next_state = GET_ADDR;
            w_next_cnt   = '0;
        end else begin
            case (r_state)
                GET_ADDR: begin
                    if (r_cnt == CNT_W'(ADDR_BITS)) begin
                        w_next_state = GOT_ADDR;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_cnt = r_cnt + CNT_W'(1);
                    end
                end
                GOT_ADDR: begin
                    // The only state where the R/W bit is meaningful.
                    w_next_state = shift_reg_out ? READ_LOAD : WRITE_GET;
                    w_next_cnt   = '0;
                end
                READ_LOAD: begin
                    w_next_state = READ_SHIFT;
                    w_next_cnt   = '0;
                end
                READ_SHIFT: begin
                    if (r_cnt == CNT_W'(DATA_BITS - 1)) begin
                        w_next_state = DONE;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_cnt = r_cnt + CNT_W'(1);
                    end
                end
                WRITE_GET: begin
                    if (r_cnt == CNT_W'(DATA_BITS - 1)) begin
                        w_next_state = WRITE_MEM;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_cnt = r_cnt + CNT_W'(1);
                    end
                end
                WRITE_MEM: begin
                    w_next_state = DONE;
                    w_next_cnt   = '0;
                end
                DONE: begin
                    w_next_state = DONE;
                    w_next_cnt   = '0;
                end
                default: begin
                    // Unused encoding (7): recover to address collection.
                    w_next_state = GET_ADDR;
                    w_next_cnt   = '0;
                end
            endcase
        end
    end

    // Moore output decode: one-hot by construction.
    always_comb begin
        miso_buff = 1'b0;
        dm_we     = 1'b0;
        addr_we   = 1'b0;
        sr_we     = 1'b0;
        case (r_state)
            GOT_ADDR:   addr_we   = 1'b1;
            READ_LOAD:  sr_we     = 1'b1;
            READ_SHIFT: miso_buff = 1'b1;
            WRITE_MEM:  dm_we     = 1'b1;
            default: ;
        endcase
    end

`ifdef SPI_FSM_STATE_OUT_EN
    assign state_dbg = r_state;
`endif

endmodule

// File: tb/tb_spi_slave_fsm.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_fsm
//
// Self-checking bench for spi_slave_fsm. A driver issues one sclk edge at a
// time; a frame-level reference model (edges since frame start plus the
// captured R/W bit) yields the expected outputs, which are queued. A monitor
// on the falling edge pops and compares against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_spi_slave_fsm;

    localparam int ADDR_BITS = 7;
    localparam int DATA_BITS = 8;
    localparam int ADDR_EDGES = ADDR_BITS + 1;

    logic sclk;
    logic reset_n;
    logic chip_sel;
    logic shift_reg_out;
    logic miso_buff;
    logic dm_we;
    logic addr_we;
    logic sr_we;
`ifdef SPI_FSM_STATE_OUT_EN
    logic [2:0] state_dbg;
`endif

    spi_slave_fsm #(
        .ADDR_BITS(ADDR_BITS),
        .DATA_BITS(DATA_BITS)
    ) dut (
        .sclk(sclk),
        .reset_n(reset_n),
        .chip_sel(chip_sel),
        .shift_reg_out(shift_reg_out),
        .miso_buff(miso_buff),
        .dm_we(dm_we),
        .addr_we(addr_we),
`ifdef SPI_FSM_STATE_OUT_EN
        .sr_we(sr_we),
        .state_dbg(state_dbg)
`else
        .sr_we(sr_we)
`endif
    );

    // ---------------- clock ----------------
    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // ---------------- scoreboard state ----------------
    // Entry layout: {state[2:0], miso_buff, dm_we, addr_we, sr_we}
    logic [6:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: edges seen in the current frame and the R/W bit.
    int m_k  = 0;
    bit m_rw = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs {miso, dm, addr, sr} after k edges of a frame.
    function automatic logic [3:0] model_outs(input int k, input bit rw);
        if (k == ADDR_EDGES) return 4'b0010;
        if (k <= ADDR_EDGES) return 4'b0000;
        if (rw) begin
            if (k == ADDR_EDGES + 1) return 4'b0001;
            if (k >= ADDR_EDGES + 2 && k <= ADDR_EDGES + 1 + DATA_BITS) return 4'b1000;
            return 4'b0000;
        end
        if (k == ADDR_EDGES + 1 + DATA_BITS) return 4'b0100;
        return 4'b0000;
    endfunction

    function automatic logic [2:0] model_state(input int k, input bit rw);
        if (k < ADDR_EDGES) return 3'd0;
        if (k == ADDR_EDGES) return 3'd1;
        if (rw) begin
            if (k == ADDR_EDGES + 1) return 3'd2;
            if (k <= ADDR_EDGES + 1 + DATA_BITS) return 3'd3;
            return 3'd6;
        end
        if (k <= ADDR_EDGES + DATA_BITS) return 3'd4;
        if (k == ADDR_EDGES + 1 + DATA_BITS) return 3'd5;
        return 3'd6;
    endfunction

    function automatic logic [7:0] dut_outs();
        return {4'b0, miso_buff, dm_we, addr_we, sr_we};
    endfunction

    // ---------------- driver ----------------
    // Apply inputs, take one rising edge, advance the model, queue expectation.
    task automatic step(input bit cs, input bit sro);
        chip_sel      = cs;
        shift_reg_out = sro;
        @(posedge sclk);
        if (cs) begin
            m_k = 0;
        end else begin
            if (m_k == ADDR_EDGES) m_rw = sro;
            if (m_k < 1000) m_k++;
        end
        #1;
        exp_q.push_back({model_state(m_k, m_rw), model_outs(m_k, m_rw)});
    endtask

    task automatic steps(input int n, input bit cs, input bit sro);
        for (int i = 0; i < n; i++) step(cs, sro);
    endtask

    // Asynchronous reset between edges; outputs must clear with no sclk edge.
    task automatic mid_reset();
        @(negedge sclk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outs", dut_outs(), 8'h00);
`ifdef SPI_FSM_STATE_OUT_EN
        check("async_reset_state", {5'b0, state_dbg}, 8'h00);
`endif
        m_k  = 0;
        m_rw = 1'b0;
        @(posedge sclk);
        @(negedge sclk);
        #1;
        check("reset_hold_outs", dut_outs(), 8'h00);
        reset_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge sclk) begin
        if (exp_q.size() > 0) begin
            logic [6:0] e;
            e = exp_q.pop_front();
            check("outs", dut_outs(), {4'b0, e[3:0]});
            check("onehot0", {7'b0, $onehot0({miso_buff, dm_we, addr_we, sr_we})}, 8'h01);
`ifdef SPI_FSM_STATE_OUT_EN
            check("state_dbg", {5'b0, state_dbg}, {5'b0, e[6:4]});
`endif
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_n       = 1'b0;
        chip_sel      = 1'b1;
        shift_reg_out = 1'b0;
        @(posedge sclk);
        #1;
        check("reset_outs", dut_outs(), 8'h00);
        @(negedge sclk);
        #2;
        reset_n = 1'b1;
        step(1'b1, 1'b0);

        // Read frame
        steps(ADDR_EDGES, 1'b0, 1'b0);
        step(1'b0, 1'b1);
        steps(DATA_BITS + 3, 1'b0, 1'b0);
        step(1'b1, 1'b0);

        // Write frame, then DONE hold for 20 edges, then a new read frame
        steps(ADDR_EDGES, 1'b0, 1'b1);
        step(1'b0, 1'b0);
        steps(DATA_BITS + 2, 1'b0, 1'b1);
        steps(20, 1'b0, 1'b1);
        step(1'b1, 1'b0);
        steps(ADDR_EDGES, 1'b0, 1'b0);
        step(1'b0, 1'b1);
        steps(DATA_BITS + 2, 1'b0, 1'b0);
        step(1'b1, 1'b0);

        // Abort at edge 5 of address collection, then a full restart
        steps(4, 1'b0, 1'b0);
        step(1'b1, 1'b0);
        steps(ADDR_EDGES + 2, 1'b0, 1'b0);
        step(1'b1, 1'b0);

        // R/W isolation: toggle during address phase, 0 at the decision edge
        for (int i = 0; i < ADDR_EDGES; i++) step(1'b0, i[0] ? 1'b0 : 1'b1);
        step(1'b0, 1'b0);
        for (int i = 0; i < DATA_BITS + 3; i++) step(1'b0, i[0]);
        step(1'b1, 1'b0);

        // Reset in the middle of READ_SHIFT, then address collection again
        steps(ADDR_EDGES, 1'b0, 1'b0);
        step(1'b0, 1'b1);
        steps(3, 1'b0, 1'b0);
        mid_reset();
        steps(ADDR_EDGES + 1, 1'b0, 1'b1);
        step(1'b1, 1'b0);

        // Randomized frames with random aborts
        for (int f = 0; f < 60; f++) begin
            int len;
            len = $urandom_range(0, 30);
            for (int e = 0; e < len; e++) begin
                step(($urandom_range(0, 40) == 0), 1'($urandom_range(0, 1)));
            end
            step(1'b1, 1'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge sclk);
        #1;
        check("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
